// File: rtl/riskow_gpio_port_if.sv
// Word-addressed CPU bus between the Riskow core and the GPIO port.
// Each request completes with a one-cycle busReady pulse on the following cycle.
interface riskow_gpio_port_if;
  logic        busValid;
  logic        busWrite;
  logic [3:0]  busAddress;
  logic [31:0] busDataIn;
  logic [31:0] busDataOut;
  logic        busReady;

  modport master (
    output busValid,
    output busWrite,
    output busAddress,
    output busDataIn,
    input  busDataOut,
    input  busReady
  );

  modport slave (
    input  busValid,
    input  busWrite,
    input  busAddress,
    input  busDataIn,
    output busDataOut,
    output busReady
  );
endinterface

// File: rtl/riskow_gpio_port.sv
// Parametrised GPIO port: per-pin direction, atomic set/clear/toggle, synchronised inputs
// and sticky edge-interrupt status with write-1-to-clear.
module riskow_gpio_port #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic               clk,
  input  logic               reset,
  riskow_gpio_port_if.slave  bus,
  inout  wire  [WIDTH-1:0]   pins,
  output logic               irq
);

  localparam logic [3:0] AddrDir    = 4'd0;
  localparam logic [3:0] AddrOut    = 4'd1;
  localparam logic [3:0] AddrIn     = 4'd2;
  localparam logic [3:0] AddrSet    = 4'd3;
  localparam logic [3:0] AddrClr    = 4'd4;
  localparam logic [3:0] AddrTgl    = 4'd5;
  localparam logic [3:0] AddrRiseEn = 4'd6;
  localparam logic [3:0] AddrFallEn = 4'd7;
  localparam logic [3:0] AddrStatus = 4'd8;

  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] prev_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic             ready_q;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] events;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign pins[i] = dir_q[i] ? 1'bz : out_q[i];
  end

  assign wr        = bus.busValid & bus.busWrite;
  assign wdata     = bus.busDataIn[WIDTH-1:0];
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign events    = (sync_last & ~prev_q & rise_en_q) | (~sync_last & prev_q & fall_en_q);

  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr) begin
      case (bus.busAddress)
        AddrDir:    dir_d     = wdata;
        AddrOut:    out_d     = wdata;
        AddrSet:    out_d     = out_q | wdata;
        AddrClr:    out_d     = out_q & ~wdata;
        AddrTgl:    out_d     = out_q ^ wdata;
        AddrRiseEn: rise_en_d = wdata;
        AddrFallEn: fall_en_d = wdata;
        AddrStatus: w1c       = wdata;
        default:    ;
      endcase
    end
    // A new event outranks a simultaneous clear so no edge is ever lost.
    status_d = (status_q & ~w1c) | events;
  end

  always_comb begin
    rdata_d = '0;
    if (bus.busValid && !bus.busWrite) begin
      case (bus.busAddress)
        AddrDir:    rdata_d = 32'(dir_q);
        AddrOut:    rdata_d = 32'(out_q);
        AddrIn:     rdata_d = 32'(sync_last);
        AddrRiseEn: rdata_d = 32'(rise_en_q);
        AddrFallEn: rdata_d = 32'(fall_en_q);
        AddrStatus: rdata_d = 32'(status_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q     <= DIR_RESET;
      out_q     <= OUT_RESET;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      sync_q    <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      dir_q     <= dir_d;
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= sync_last;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pins};
      ready_q   <= bus.busValid;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.busReady   = ready_q;
  assign bus.busDataOut = rdata_q;
  assign irq            = |status_q;

endmodule

// File: tb/tb_riskow_gpio_port.sv
// Directed bench for riskow_gpio_port: a 32-pin instance for most scenarios and an
// 8-pin instance for register-width masking.
module tb_riskow_gpio_port;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riskow_gpio_port_if bus32 ();
  riskow_gpio_port_if bus8 ();

  wire  [31:0] pins32;
  wire  [7:0]  pins8;
  logic        irq32, irq8;
  logic [31:0] tb_en, tb_val;

  for (genvar i = 0; i < 32; i++) begin : g_drv
    assign pins32[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  riskow_gpio_port dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave),
    .pins  (pins32),
    .irq   (irq32)
  );

  riskow_gpio_port #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave),
    .pins  (pins8),
    .irq   (irq8)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic bus_xfer(input bit n8, input bit wr, input logic [3:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic rdy);
    @(negedge clk);
    if (n8) begin
      bus8.busValid = 1'b1; bus8.busWrite = wr; bus8.busAddress = a; bus8.busDataIn = d;
    end else begin
      bus32.busValid = 1'b1; bus32.busWrite = wr; bus32.busAddress = a; bus32.busDataIn = d;
    end
    @(posedge clk);
    #1;
    rd  = n8 ? bus8.busDataOut : bus32.busDataOut;
    rdy = n8 ? bus8.busReady : bus32.busReady;
    bus8.busValid  = 1'b0;
    bus32.busValid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        rdy;
    reset = 1'b1;
    bus32.busValid = 1'b1; bus32.busWrite = 1'b1; bus32.busAddress = 4'd0;
    bus32.busDataIn = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus32.busReady !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_hold: got %b want 0", bus32.busReady);
    end
    @(negedge clk);
    reset = 1'b0;
    bus32.busValid = 1'b0;
    bus_xfer(0, 0, 4'd0, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'hFFFF_FFFF || rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_dir_ignored_write: got %h/%b want ffffffff/1", rd, rdy);
    end
    bus_xfer(0, 1, 4'd1, 32'h55, rd, rdy);
    bus_xfer(0, 1, 4'd0, 32'h0, rd, rdy);
    // Read in flight, then reset lands mid-cycle while busReady is high.
    @(negedge clk);
    bus32.busValid = 1'b1; bus32.busWrite = 1'b0; bus32.busAddress = 4'd1;
    @(posedge clk);
    #1;
    bus32.busValid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus32.busReady !== 1'b0 || bus32.busDataOut !== 32'h0 || irq32 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: got ready=%b data=%h irq=%b want 0/0/0",
               bus32.busReady, bus32.busDataOut, irq32);
    end
    @(negedge clk);
    reset = 1'b0;
    bus_xfer(0, 0, 4'd0, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL reset_dir: got %h want ffffffff", rd);
    end
    bus_xfer(0, 0, 4'd1, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_out: got %h want 00000000", rd);
    end
  endtask

  task automatic test_output_ops();
    logic [31:0] rd;
    logic        rdy;
    bus_xfer(0, 1, 4'd0, 32'h0000_0000, rd, rdy);
    bus_xfer(0, 1, 4'd1, 32'h0000_00F0, rd, rdy);
    bus_xfer(0, 1, 4'd3, 32'h0000_000F, rd, rdy);
    bus_xfer(0, 1, 4'd4, 32'h0000_0030, rd, rdy);
    bus_xfer(0, 1, 4'd5, 32'h8000_0001, rd, rdy);
    bus_xfer(0, 0, 4'd1, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h8000_00CE) begin
      miscompares++;
      $display("FAIL out_ops_read: got %h want 800000ce", rd);
    end
    vectors++;
    if (pins32 !== 32'h8000_00CE) begin
      miscompares++;
      $display("FAIL out_ops_pins: got %h want 800000ce", pins32);
    end
    repeat (2) @(posedge clk);
    bus_xfer(0, 0, 4'd2, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h8000_00CE) begin
      miscompares++;
      $display("FAIL out_ops_in: got %h want 800000ce", rd);
    end
  endtask

  task automatic test_narrow();
    logic [31:0] rd;
    logic        rdy;
    bus_xfer(1, 1, 4'd0, 32'hFFFF_FF00, rd, rdy);
    bus_xfer(1, 1, 4'd1, 32'h1234_5678, rd, rdy);
    bus_xfer(1, 0, 4'd0, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL narrow_dir: got %h want 00000000", rd);
    end
    bus_xfer(1, 0, 4'd1, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h0000_0078) begin
      miscompares++;
      $display("FAIL narrow_out: got %h want 00000078", rd);
    end
    vectors++;
    if (pins8 !== 8'h78) begin
      miscompares++;
      $display("FAIL narrow_pins: got %h want 78", pins8);
    end
    bus_xfer(1, 0, 4'd12, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h0 || rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL narrow_addr12: got %h/%b want 00000000/1", rd, rdy);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd;
    logic        rdy;
    bus_xfer(0, 1, 4'd0, 32'hFFFF_FFFF, rd, rdy);
    @(negedge clk);
    tb_val = 32'h0000_0002;
    tb_en  = 32'hFFFF_FFFF;
    bus_xfer(0, 1, 4'd6, 32'h1, rd, rdy);
    bus_xfer(0, 1, 4'd7, 32'h2, rd, rdy);
    repeat (4) @(posedge clk);
    bus_xfer(0, 0, 4'd8, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL edge_status_idle: got %h want 00000000", rd);
    end
    @(negedge clk);
    tb_val = 32'h0000_0001;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (irq32 !== (e == 3)) begin
        miscompares++;
        $display("FAIL edge_irq_latency_%0d: got %b want %b", e, irq32, e == 3);
      end
    end
    bus_xfer(0, 0, 4'd8, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h3) begin
      miscompares++;
      $display("FAIL edge_status: got %h want 00000003", rd);
    end
    @(negedge clk);
    tb_val = 32'h0;
    repeat (5) @(posedge clk);
    bus_xfer(0, 0, 4'd8, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h3) begin
      miscompares++;
      $display("FAIL edge_pin0_fall: got %h want 00000003", rd);
    end
    bus_xfer(0, 1, 4'd8, 32'h3, rd, rdy);
    bus_xfer(0, 0, 4'd8, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h0 || irq32 !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_clear: got %h irq=%b want 00000000 irq=0", rd, irq32);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    logic        rdy;
    @(negedge clk);
    tb_val = 32'h1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    tb_val = 32'h0;
    repeat (5) @(posedge clk);
    bus_xfer(0, 0, 4'd8, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h1) begin
      miscompares++;
      $display("FAIL w1c_setup: got %h want 00000001", rd);
    end
    // New rise lands on the third edge after the pin change, same edge as the clear.
    @(negedge clk);
    tb_val = 32'h1;
    repeat (2) @(posedge clk);
    bus_xfer(0, 1, 4'd8, 32'h1, rd, rdy);
    bus_xfer(0, 0, 4'd8, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h1) begin
      miscompares++;
      $display("FAIL w1c_race: got %h want 00000001", rd);
    end
    bus_xfer(0, 1, 4'd8, 32'h1, rd, rdy);
    bus_xfer(0, 0, 4'd8, 32'h0, rd, rdy);
    vectors++;
    if (rd !== 32'h0 || irq32 !== 1'b0) begin
      miscompares++;
      $display("FAIL w1c_clear: got %h irq=%b want 00000000 irq=0", rd, irq32);
    end
  endtask

  task automatic test_back_to_back();
    logic        wr_t [4];
    logic [3:0]  a_t  [4];
    logic [31:0] exp_t[4];
    wr_t[0] = 1'b1; a_t[0] = 4'd1;  exp_t[0] = 32'h0;
    wr_t[1] = 1'b0; a_t[1] = 4'd1;  exp_t[1] = 32'h1234_ABCD;
    wr_t[2] = 1'b0; a_t[2] = 4'd2;  exp_t[2] = 32'h0000_0001;
    wr_t[3] = 1'b0; a_t[3] = 4'd15; exp_t[3] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus32.busValid = 1'b1; bus32.busWrite = wr_t[k]; bus32.busAddress = a_t[k];
      bus32.busDataIn = 32'h1234_ABCD;
      @(posedge clk);
      #1;
      vectors++;
      if (bus32.busReady !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready_%0d: got %b want 1", k, bus32.busReady);
      end
      if (k != 0) begin
        vectors++;
        if (bus32.busDataOut !== exp_t[k]) begin
          miscompares++;
          $display("FAIL b2b_data_%0d: got %h want %h", k, bus32.busDataOut, exp_t[k]);
        end
      end
    end
    @(negedge clk);
    bus32.busValid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus32.busReady !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got %b want 0", bus32.busReady);
    end
  endtask

  initial begin
    tb_en  = 32'h0;
    tb_val = 32'h0;
    bus8.busValid  = 1'b0; bus8.busWrite  = 1'b0; bus8.busAddress  = 4'd0; bus8.busDataIn  = '0;
    bus32.busValid = 1'b0; bus32.busWrite = 1'b0; bus32.busAddress = 4'd0; bus32.busDataIn = '0;
    test_reset();
    test_output_ops();
    test_narrow();
    test_edge_irq();
    test_w1c_race();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
